// File: rtl/im_loader.sv
// im_loader: loads a program into the instruction store from a byte stream.
//
// Bytes arrive on a valid/ready handshake and are paired into big-endian
// 16-bit words (the first byte of a pair is the high byte). Each completed
// word is written once through the word-wide write port, at consecutive even
// byte addresses starting from BASE_ADDR. The write address wraps modulo 2^16.
//
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
// byte_ready depends only on state, so the sender may leave byte_valid high
// indefinitely and the loader takes bytes as it becomes ready.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start           one-cycle load request, honoured in IDLE or DONE only
//   word_count      number of words to load, latched on an accepted start
//   abort           return to IDLE at the next edge (wins over start)
//   byte_valid/data incoming stream byte
//   byte_ready      loader takes a byte this cycle (HI and LO states)
//   we/waddr/wdata  one-cycle word write, {high byte, low byte}
//   busy            load in progress (HI, LO, WRITE)
//   done            load complete, held until next accepted start or abort
//   checksum        mod-256 sum of bytes accepted since the last start
//   dbg_state       current FSM state, for observation only
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        abort,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  checksum,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Words are always written at even addresses.
  localparam logic [15:0] BASE_EVEN = BASE_ADDR & 16'hFFFE;

  state_t      r_state;
  logic [15:0] r_remaining;
  logic [15:0] r_addr;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [7:0]  r_checksum;

  logic w_accept;
  assign w_accept = byte_valid && (r_state == S_HI || r_state == S_LO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= 16'd0;
      r_addr      <= BASE_EVEN;
      r_hi        <= 8'd0;
      r_lo        <= 8'd0;
      r_checksum  <= 8'd0;
    end else if (abort) begin
      // Partial words are simply dropped; checksum keeps its value.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_remaining <= word_count;
            r_addr      <= BASE_EVEN;
            r_checksum  <= 8'd0;
            r_state     <= (word_count == 16'd0) ? S_DONE : S_HI;
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_hi       <= byte_data;
            r_checksum <= r_checksum + byte_data;
            r_state    <= S_LO;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_lo       <= byte_data;
            r_checksum <= r_checksum + byte_data;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + 16'd2;
          r_remaining <= r_remaining - 16'd1;
          r_state     <= (r_remaining == 16'd1) ? S_DONE : S_HI;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from state or taken straight from registers, so an
  // abort during WRITE still lets that cycle's write go out.
  assign byte_ready = (r_state == S_HI) || (r_state == S_LO);
  assign we         = (r_state == S_WRITE);
  assign busy       = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_WRITE);
  assign done       = (r_state == S_DONE);
  assign waddr      = r_addr;
  assign wdata      = {r_hi, r_lo};
  assign checksum   = r_checksum;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] word_count = 16'd0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;

  logic        byte_ready0, we0, busy0, done0;
  logic [15:0] waddr0, wdata0;
  logic [7:0]  checksum0;
  logic [2:0]  dbg_state0;
  logic        byte_ready1, we1, busy1, done1;
  logic [15:0] waddr1, wdata1;
  logic [7:0]  checksum1;
  logic [2:0]  dbg_state1;

  localparam logic [15:0] BASE0 = 16'h0000;
  localparam logic [15:0] BASE1 = 16'hFFFE;

  // Two loaders see identical stimulus; the second one exercises address wrap.
  im_loader #(.BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready0), .we(we0), .waddr(waddr0), .wdata(wdata0),
    .busy(busy0), .done(done0), .checksum(checksum0), .dbg_state(dbg_state0)
  );
  im_loader #(.BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready1), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .checksum(checksum1), .dbg_state(dbg_state1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int t_start = 0;

  logic [7:0]  byte_q[$];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [31:0] obs0_q[$];
  logic [31:0] obs1_q[$];
  int          obs_cyc_q[$];

  always @(negedge clk) begin
    if (we0) begin
      obs0_q.push_back({waddr0, wdata0});
      obs_cyc_q.push_back(cyc);
    end
    if (we1) obs1_q.push_back({waddr1, wdata1});
  end

  function automatic int first_diff(input logic [31:0] a[$], input logic [31:0] b[$]);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic logic [31:0] at_or_zero(input logic [31:0] a[$], input int i);
    if (i >= 0 && i < a.size()) return a[i];
    return 32'h0;
  endfunction

  // Reference model: the first n_words byte pairs become words at base+2i.
  task automatic build_exp(input int n_words);
    logic [15:0] a0, a1;
    exp0_q.delete();
    exp1_q.delete();
    a0 = BASE0 & 16'hFFFE;
    a1 = BASE1 & 16'hFFFE;
    for (int i = 0; i < n_words; i++) begin
      exp0_q.push_back({a0, byte_q[2*i], byte_q[2*i+1]});
      exp1_q.push_back({a1, byte_q[2*i], byte_q[2*i+1]});
      a0 = a0 + 16'd2;
      a1 = a1 + 16'd2;
    end
  endtask

  function automatic logic [7:0] model_sum(input int n_bytes);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < n_bytes; i++) s = s + byte_q[i];
    return s;
  endfunction

  task automatic clear_obs();
    obs0_q.delete();
    obs1_q.delete();
    obs_cyc_q.delete();
  endtask

  // ---------------- drivers (entered/left at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    word_count = n;
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 1'b0;
    word_count = 16'($urandom);
  endtask

  task automatic send_stream(input int prob, input string name);
    int idx;
    int guard;
    logic acc;
    idx = 0;
    guard = 0;
    while (idx < byte_q.size() && guard < 1000) begin
      if (int'($urandom_range(0, 99)) < prob) begin
        byte_valid = 1'b1;
        byte_data = byte_q[idx];
      end else begin
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
      end
      @(negedge clk);
      acc = byte_valid && byte_ready0;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    byte_valid = 1'b0;
    n_checks++;
    if (idx != byte_q.size()) $display("FAIL %s_stream: accepted %0d bytes, want %0d", name, idx, byte_q.size());
    else n_pass++;
  endtask

  task automatic wait_done(input string name);
    int g;
    logic seen;
    g = 0;
    seen = 1'b0;
    while (!seen && g < 50) begin
      @(negedge clk);
      seen = done0;
      @(posedge clk);
      #1;
      g++;
    end
    n_checks++;
    if (!seen) $display("FAIL %s_done_wait: done got 0 after %0d cycles, want 1", name, g);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    n_checks++;
    if ({we0, byte_ready0, busy0, done0} !== 4'b0000)
      $display("FAIL reset_flags: got we,rdy,busy,done=%b, want 0000", {we0, byte_ready0, busy0, done0});
    else n_pass++;
    n_checks++;
    if (waddr0 !== 16'h0000 || waddr1 !== 16'hFFFE)
      $display("FAIL reset_waddr: got %h/%h, want 0000/fffe", waddr0, waddr1);
    else n_pass++;
    n_checks++;
    if (wdata0 !== 16'h0000 || checksum0 !== 8'h00)
      $display("FAIL reset_data: got wdata=%h cks=%h, want 0000/00", wdata0, checksum0);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);
    n_checks++;
    if ({busy0, done0, busy1, done1, byte_ready1} !== 5'b0 || obs0_q.size() != 0)
      $display("FAIL reset_idle: got busy/done=%b writes=%0d, want 0/0", {busy0, done0, busy1, done1, byte_ready1}, obs0_q.size());
    else n_pass++;
  endtask

  task automatic test_basic();
    int d;
    byte_q = '{8'h01, 8'h20, 8'h01, 8'h21};
    build_exp(2);
    clear_obs();
    do_start(16'd2);
    send_stream(100, "basic");
    // Last low byte went in at the previous edge: this cycle is the write.
    @(negedge clk);
    n_checks++;
    if (done0 !== 1'b0 || we0 !== 1'b1 || byte_ready0 !== 1'b0)
      $display("FAIL basic_last_write: got done=%b we=%b rdy=%b, want 0 1 0", done0, we0, byte_ready0);
    else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0) $display("FAIL basic_done_rise: got done=%b busy=%b, want 1 0", done0, busy0);
    else n_pass++;
    @(posedge clk);
    #1;
    d = first_diff(obs0_q, exp0_q);
    n_checks++;
    if (d >= 0) $display("FAIL basic_writes0: got %0d writes (%h at %0d), want %0d (%h)", obs0_q.size(), at_or_zero(obs0_q, d), d, exp0_q.size(), at_or_zero(exp0_q, d));
    else n_pass++;
    d = first_diff(obs1_q, exp1_q);
    n_checks++;
    if (d >= 0) $display("FAIL basic_writes_wrap: got %0d writes (%h at %0d), want %0d (%h)", obs1_q.size(), at_or_zero(obs1_q, d), d, exp1_q.size(), at_or_zero(exp1_q, d));
    else n_pass++;
    n_checks++;
    if (obs_cyc_q.size() != 2 || obs_cyc_q[0] != t_start + 2 || obs_cyc_q[1] != t_start + 5)
      $display("FAIL basic_write_timing: got %0d writes, first at +%0d, want 2 at +2,+5", obs_cyc_q.size(), (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - t_start : -1);
    else n_pass++;
    n_checks++;
    if (checksum0 !== 8'h43 || checksum1 !== 8'h43) $display("FAIL basic_checksum: got %h/%h, want 43", checksum0, checksum1);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic gap_ok;
    int d;
    byte_q = '{8'h23, 8'hFF};
    build_exp(1);
    clear_obs();
    do_start(16'd1);
    gap_ok = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h23;
    idle(1);
    byte_valid = 1'b0; byte_data = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      if (byte_ready0 !== 1'b1 || busy0 !== 1'b1 || we0 !== 1'b0) gap_ok = 1'b0;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1; byte_data = 8'hFF;
    idle(1);
    byte_valid = 1'b0;
    idle(3);
    n_checks++;
    if (!gap_ok) $display("FAIL stall_hold: got loader not waiting in gap, want rdy=1 busy=1 we=0");
    else n_pass++;
    d = first_diff(obs0_q, exp0_q);
    n_checks++;
    if (d >= 0) $display("FAIL stall_writes: got %0d writes (%h), want 1 (%h)", obs0_q.size(), at_or_zero(obs0_q, 0), exp0_q[0]);
    else n_pass++;
    n_checks++;
    if (checksum0 !== 8'h22 || done0 !== 1'b1) $display("FAIL stall_end: got cks=%h done=%b, want 22 1", checksum0, done0);
    else n_pass++;
  endtask

  task automatic test_zero();
    logic rdy_seen;
    clear_obs();
    byte_valid = 1'b1;
    byte_data = 8'h55;
    do_start(16'd0);
    @(negedge clk);
    n_checks++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || checksum0 !== 8'h00)
      $display("FAIL zero_done: got done=%b busy=%b cks=%h, want 1 0 00", done0, busy0, checksum0);
    else n_pass++;
    rdy_seen = byte_ready0;
    repeat (3) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      rdy_seen = rdy_seen | byte_ready0;
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    n_checks++;
    if (rdy_seen !== 1'b0 || obs0_q.size() != 0 || obs1_q.size() != 0)
      $display("FAIL zero_quiet: got rdy_seen=%b writes=%0d, want 0 0", rdy_seen, obs0_q.size());
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [7:0] full_q[$];
    int d;
    full_q.delete();
    for (int i = 0; i < 6; i++) full_q.push_back(8'($urandom));
    byte_q = full_q;
    build_exp(1);
    byte_q = full_q[0:2];
    clear_obs();
    do_start(16'd3);
    send_stream(100, "abort");
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    idle(2);
    n_checks++;
    if ({busy0, done0, byte_ready0} !== 3'b000) $display("FAIL abort_idle: got busy,done,rdy=%b, want 000", {busy0, done0, byte_ready0});
    else n_pass++;
    d = first_diff(obs0_q, exp0_q);
    n_checks++;
    if (d >= 0) $display("FAIL abort_writes: got %0d writes (%h), want 1 (%h)", obs0_q.size(), at_or_zero(obs0_q, 0), exp0_q[0]);
    else n_pass++;
    n_checks++;
    if (checksum0 !== model_sum(3)) $display("FAIL abort_checksum_hold: got %h, want %h", checksum0, model_sum(3));
    else n_pass++;
    // abort wins over a simultaneous start.
    start = 1'b1; abort = 1'b1; word_count = 16'd1;
    idle(1);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy0 !== 1'b0 || byte_ready0 !== 1'b0 || done0 !== 1'b0) $display("FAIL abort_priority: got busy=%b rdy=%b done=%b, want 000", busy0, byte_ready0, done0);
    else n_pass++;
    @(posedge clk);
    #1;
    byte_q = '{8'($urandom), 8'($urandom)};
    build_exp(1);
    clear_obs();
    do_start(16'd1);
    send_stream(70, "reload");
    wait_done("reload");
    d = first_diff(obs0_q, exp0_q);
    n_checks++;
    if (d >= 0 || checksum0 !== model_sum(2))
      $display("FAIL reload: got %0d writes (%h) cks=%h, want 1 (%h) cks=%h", obs0_q.size(), at_or_zero(obs0_q, 0), checksum0, exp0_q[0], model_sum(2));
    else n_pass++;
  endtask

  task automatic test_busy_start_and_reset();
    logic [7:0] full_q[$];
    int d;
    full_q.delete();
    for (int i = 0; i < 4; i++) full_q.push_back(8'($urandom));
    byte_q = full_q;
    build_exp(2);
    clear_obs();
    do_start(16'd2);
    byte_q = full_q[0:0];
    send_stream(100, "busy_start_a");
    start = 1'b1; word_count = 16'd5;
    idle(1);
    start = 1'b0;
    byte_q = full_q[1:3];
    send_stream(80, "busy_start_b");
    wait_done("busy_start");
    byte_q = full_q;
    d = first_diff(obs0_q, exp0_q);
    n_checks++;
    if (d >= 0 || checksum0 !== model_sum(4))
      $display("FAIL busy_start_ignored: got %0d writes cks=%h, want 2 cks=%h", obs0_q.size(), checksum0, model_sum(4));
    else n_pass++;
    // Reset while waiting for the low byte.
    byte_q = '{8'h9A};
    do_start(16'd2);
    send_stream(100, "reset_mid");
    clear_obs();
    reset = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h3C;
    #1;
    n_checks++;
    if ({we0, byte_ready0, busy0, done0} !== 4'b0000 || waddr0 !== 16'h0000 || waddr1 !== 16'hFFFE || wdata0 !== 16'h0000 || checksum0 !== 8'h00)
      $display("FAIL reset_mid: got flags=%b waddr=%h/%h wdata=%h cks=%h, want 0000 0000/fffe 0000 00", {we0, byte_ready0, busy0, done0}, waddr0, waddr1, wdata0, checksum0);
    else n_pass++;
    idle(3);
    reset = 1'b0;
    byte_valid = 1'b0;
    idle(3);
    n_checks++;
    if (obs0_q.size() != 0 || obs1_q.size() != 0) $display("FAIL reset_mid_nowrite: got %0d writes, want 0", obs0_q.size());
    else n_pass++;
  endtask

  task automatic test_random();
    int n;
    int d;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 5);
      byte_q.delete();
      for (int i = 0; i < 2 * n; i++) byte_q.push_back(8'($urandom));
      build_exp(n);
      clear_obs();
      do_start(16'(n));
      send_stream($urandom_range(40, 100), "rand");
      wait_done("rand");
      d = first_diff(obs0_q, exp0_q);
      n_checks++;
      if (d >= 0) $display("FAIL rand_writes0 it%0d: got %0d writes (%h at %0d), want %0d (%h)", it, obs0_q.size(), at_or_zero(obs0_q, d), d, exp0_q.size(), at_or_zero(exp0_q, d));
      else n_pass++;
      d = first_diff(obs1_q, exp1_q);
      n_checks++;
      if (d >= 0) $display("FAIL rand_writes1 it%0d: got %0d writes (%h at %0d), want %0d (%h)", it, obs1_q.size(), at_or_zero(obs1_q, d), d, exp1_q.size(), at_or_zero(exp1_q, d));
      else n_pass++;
      n_checks++;
      if (checksum0 !== model_sum(2 * n) || checksum1 !== model_sum(2 * n))
        $display("FAIL rand_checksum it%0d: got %h/%h, want %h", it, checksum0, checksum1, model_sum(2 * n));
      else n_pass++;
      idle($urandom_range(0, 2));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_abort();
    test_busy_start_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
